alu_mul_sequencer: RTL and testbench

- Multi-cycle controller that computes a 16-bit product by sequencing the existing combinational Hack-style ALU, which sits outside this block.
- Shift-add algorithm, processing the multiplier MSB-first:
  - Doubling is done as acc+acc.
  - Accumulation is done as acc+multiplicand.
- Drives the ALU's x, y and six control bits, and consumes its out, zr and ng.
- Serves as the multiply engine for the CPU's extended-instruction path.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_mul_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the shift-add multiply sequencer that drives a Hack-style ALU.
// MUL_SKIP_LEADING_ZERO_EN adds a leading-one detector used to skip leading zero bits of b.
package alu_seq_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDbl  = 2'd1,
    StAdd  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Field order matches the Hack ALU control word, MSB first.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_CTRL_ADD  = 6'b000010;
  localparam alu_ctrl_t ALU_CTRL_ZERO = 6'b101010;

`ifdef MUL_SKIP_LEADING_ZERO_EN
  // Index of the highest set bit; returns 0 for an all-zero input.
  function automatic logic [3:0] lead_one_idx(input logic [WIDTH_DEFAULT-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < int'(WIDTH_DEFAULT); i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction
`endif

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle 16-bit multiplier that sequences an external Hack ALU (MSB-first shift-add).
// Define MUL_SKIP_LEADING_ZERO_EN to start at the highest set bit of the multiplier.
module alu_mul_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zr_q,
  output logic             ng_q,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  localparam logic [CNT_W-1:0] IdxTop = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zr_d, ng_d;
  logic             zr_r, ng_r;
  alu_ctrl_t        ctrl;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    idx_d    = idx_q;
    result_d = result_q;
    zr_d     = zr_r;
    ng_d     = ng_r;
    alu_x    = '0;
    alu_y    = '0;
    ctrl     = ALU_CTRL_ZERO;

    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          state_d  = StDbl;
`ifdef MUL_SKIP_LEADING_ZERO_EN
          idx_d = CNT_W'(lead_one_idx(b));
          if (b == '0) begin
            state_d  = StDone;
            result_d = '0;
            zr_d     = 1'b1;
            ng_d     = 1'b0;
          end
`else
          idx_d = IdxTop;
`endif
        end
      end

      StDbl: begin
        alu_x = acc_q;
        alu_y = acc_q;
        ctrl  = ALU_CTRL_ADD;
        acc_d = alu_out;
        if (mplier_q[idx_q]) begin
          state_d = StAdd;
        end else if (idx_q == '0) begin
          // Final step: the ALU flags of this sum are the product's flags.
          state_d  = StDone;
          result_d = alu_out;
          zr_d     = alu_zr;
          ng_d     = alu_ng;
        end else begin
          idx_d = idx_q - CNT_W'(1);
        end
      end

      StAdd: begin
        alu_x = acc_q;
        alu_y = mcand_q;
        ctrl  = ALU_CTRL_ADD;
        acc_d = alu_out;
        if (idx_q == '0) begin
          state_d  = StDone;
          result_d = alu_out;
          zr_d     = alu_zr;
          ng_d     = alu_ng;
        end else begin
          idx_d   = idx_q - CNT_W'(1);
          state_d = StDbl;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      idx_q    <= IdxTop;
      result_q <= '0;
      zr_r     <= 1'b0;
      ng_r     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      zr_r     <= zr_d;
      ng_r     <= ng_d;
    end
  end

  assign busy   = (state_q == StDbl) || (state_q == StAdd);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign zr_q   = zr_r;
  assign ng_q   = ng_r;

  assign alu_zx = ctrl.zx;
  assign alu_nx = ctrl.nx;
  assign alu_zy = ctrl.zy;
  assign alu_ny = ctrl.ny;
  assign alu_f  = ctrl.f;
  assign alu_no = ctrl.no;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a behavioural Hack ALU is wired to the sequencer, and a
// latency/product model is compared against the outputs every cycle.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] a, b;
  logic        busy, done, zr_q, ng_q;
  logic [15:0] result, alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zr_q(zr_q), .ng_q(ng_q),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  // Hack ALU
  logic [15:0] hx, hy, ho;
  always_comb begin
    hx = alu_zx ? 16'h0 : alu_x;
    hx = alu_nx ? ~hx : hx;
    hy = alu_zy ? 16'h0 : alu_y;
    hy = alu_ny ? ~hy : hy;
    ho = alu_f ? (hx + hy) : (hx & hy);
    ho = alu_no ? ~ho : ho;
  end
  assign alu_out = ho;
  assign alu_zr  = (ho == 16'h0);
  assign alu_ng  = ho[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] bv);
    int pc, msb;
    pc  = 0;
    msb = 0;
    for (int i = 0; i < 16; i++) begin
      if (bv[i]) begin
        pc++;
        msb = i;
      end
    end
`ifdef MUL_SKIP_LEADING_ZERO_EN
    if (bv == 16'h0) return 1;
    return (msb + 1) + pc + 1;
`else
    return 16 + pc + 1;
`endif
  endfunction

  function automatic int pick(input int full, input int skip);
`ifdef MUL_SKIP_LEADING_ZERO_EN
    return skip;
`else
    return full;
`endif
  endfunction

  // Model: cycles since acceptance; busy while 1..lat-1, done at lat.
  int          m_cnt = 0;
  int          m_lat = 0;
  logic [15:0] m_prod, m_res;
  logic        m_zr, m_ng;
  logic [15:0] p_tmp;
  int          l_tmp;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0;
      m_res <= 16'h0;
      m_zr  <= 1'b0;
      m_ng  <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        p_tmp = a * b;
        l_tmp = exp_lat(b);
        m_prod <= p_tmp;
        m_lat  <= l_tmp;
        m_cnt  <= 1;
        if (l_tmp == 1) begin
          m_res <= p_tmp;
          m_zr  <= (p_tmp == 16'h0);
          m_ng  <= p_tmp[15];
        end
      end
    end else if (m_cnt == m_lat) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == m_lat) begin
        m_res <= m_prod;
        m_zr  <= (m_prod == 16'h0);
        m_ng  <= m_prod[15];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, (m_cnt >= 1) && (m_cnt < m_lat));
      check("done", done, (m_cnt != 0) && (m_cnt == m_lat));
      check("result", result, m_res);
      check("zr_q", zr_q, m_zr);
      check("ng_q", ng_q, m_ng);
      if (!((m_cnt >= 1) && (m_cnt < m_lat))) begin
        check("idle_alu_x", alu_x, 16'h0);
        check("idle_alu_y", alu_y, 16'h0);
        check("idle_ctrl", {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 6'b101010);
      end
    end
  end

  // Directed multiply; disturb_at >= 1 pulses start with other operands mid-operation.
  task automatic run(input string name, input logic [15:0] av, input logic [15:0] bv,
                     input logic [15:0] er, input logic ez, input logic en, input int el,
                     input int disturb_at);
    int k, nb;
    bit seen;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    k = 0;
    nb = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (busy) nb++;
      if (done) seen = 1'b1;
      if (k == disturb_at) begin
        a = 16'd7;
        b = 16'd9;
        start = 1'b1;
      end
    end
    check({name, "_done_seen"}, seen, 1'b1);
    check({name, "_latency"}, k, el);
    check({name, "_busy_cycles"}, nb, el - 1);
    check({name, "_result"}, result, er);
    check({name, "_zr"}, zr_q, ez);
    check({name, "_ng"}, ng_q, en);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    a = 16'h0;
    b = 16'h0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 16'h0);
    check("rst_zr", zr_q, 1'b0);
    check("rst_ng", ng_q, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run("mul_3x5", 16'd3, 16'd5, 16'h000F, 1'b0, 1'b0, pick(19, 6), -1);
    run("mul_b0", 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, pick(17, 1), -1);
    run("mul_ffffx1", 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b1, pick(18, 3), -1);
    run("mul_wrap", 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, pick(18, 11), -1);
    run("mul_neg3x7", 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 1'b1, pick(20, 7), -1);
    run("mul_busy_start", 16'd3, 16'd5, 16'h000F, 1'b0, 1'b0, pick(19, 6), 3);

    // Reset in the fifth cycle of a long multiply
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 16'h0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    run("mul_ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 33, -1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
